// File: rtl/riscv_pkg.sv
// Shared RV32I load encodings and the load-unit FSM state type.
// Imported by the load extender, the load unit top and its bench.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/load_extender.sv
// Combinational byte-lane select and sign/zero extension for RV32I loads.
// Also flags misaligned lanes and illegal funct3 codes; shared with the store path checker.
module load_extender
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] data,
  output logic              misal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data  = '0;
    misal = 1'b0;
    case (funct3)
      F3_LB: begin
        data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      end
      F3_LBU: begin
        data = {{(DATA_W-8){1'b0}}, byte_sel};
      end
      F3_LH: begin
        data  = {{(DATA_W-16){half_sel[15]}}, half_sel};
        misal = addr_lo[0];
      end
      F3_LHU: begin
        data  = {{(DATA_W-16){1'b0}}, half_sel};
        misal = addr_lo[0];
      end
      F3_LW: begin
        data  = word;
        misal = (addr_lo != 2'd0);
      end
      // Reserved load encodings are reported through the same flag.
      default: begin
        data  = '0;
        misal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mdr_load_unit.sv
// Memory data register for the multicycle datapath: waits for memory read data,
// extends it per the load type and holds it until the register-file side takes it.
module mdr_load_unit
  import riscv_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_req,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  input  logic              ld_ack,
  input  logic              err_clr,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              err_misal,
  output logic              err_tmo,
  output state_t            fsm_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  if (DATA_W != 32) begin : g_bad_width
    $error("mdr_load_unit: only DATA_W = 32 is supported");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("mdr_load_unit: TIMEOUT must be in 1..65535");
  end

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lane_q, lane_d;
  logic [DATA_W-1:0] data_d;
  logic              busy_d, valid_d, misal_d, tmo_d;
  logic              take_req;

  logic [2:0]        ext_f3;
  logic [1:0]        ext_lane;
  logic [DATA_W-1:0] ext_data;
  logic              ext_misal;

  // While waiting, extend with the latched request; otherwise check the incoming one.
  assign ext_f3   = (state_q == ST_WAIT) ? f3_q   : ld_funct3;
  assign ext_lane = (state_q == ST_WAIT) ? lane_q : addr_lo;

  load_extender #(
    .DATA_W (DATA_W)
  ) u_ext (
    .funct3  (ext_f3),
    .addr_lo (ext_lane),
    .word    (mem_rdata),
    .data    (ext_data),
    .misal   (ext_misal)
  );

  // Handshakes: memory side transfers on a cycle with mem_valid=1 while busy;
  // consumer side transfers on a cycle with data_valid=1 and ld_ack=1.
  // data_out/data_valid never change while data_valid=1 and ld_ack=0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    lane_d   = lane_q;
    data_d   = data_out;
    misal_d  = err_misal;
    tmo_d    = err_tmo;
    take_req = 1'b0;

    case (state_q)
      ST_IDLE: begin
        take_req = ld_req;
      end
      ST_WAIT: begin
        if (mem_valid) begin
          data_d  = ext_data;
          state_d = ST_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERR;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (ld_ack) begin
          state_d  = ST_IDLE;
          take_req = ld_req;
        end
      end
      ST_ERR: begin
        if (err_clr) begin
          state_d = ST_IDLE;
          misal_d = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A HOLD exit with a pending request goes straight to WAIT/ERR, no IDLE bubble.
    if (take_req) begin
      f3_d   = ld_funct3;
      lane_d = addr_lo;
      cnt_d  = '0;
      if (ext_misal) begin
        state_d = ST_ERR;
        misal_d = 1'b1;
      end else begin
        state_d = ST_WAIT;
      end
    end

    busy_d  = (state_d == ST_WAIT);
    valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      f3_q       <= '0;
      lane_q     <= '0;
      busy       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      err_misal  <= 1'b0;
      err_tmo    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      f3_q       <= f3_d;
      lane_q     <= lane_d;
      busy       <= busy_d;
      data_out   <= data_d;
      data_valid <= valid_d;
      err_misal  <= misal_d;
      err_tmo    <= tmo_d;
    end
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_mdr_load_unit.sv
// Bench for mdr_load_unit: transaction-level model of the load unit checked every
// cycle, plus hand-computed literal expectations for the directed scenarios.
module tb_mdr_load_unit;
  import riscv_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_req = 1'b0;
  logic [2:0]  ld_funct3 = 3'b000;
  logic [1:0]  addr_lo = 2'd0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_valid = 1'b0;
  logic        ld_ack = 1'b0;
  logic        err_clr = 1'b0;
  logic        busy;
  logic [31:0] data_out;
  logic        data_valid;
  logic        err_misal;
  logic        err_tmo;
  state_t      fsm_state;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  mdr_load_unit #(.DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_req     (ld_req),
    .ld_funct3  (ld_funct3),
    .addr_lo    (addr_lo),
    .mem_rdata  (mem_rdata),
    .mem_valid  (mem_valid),
    .ld_ack     (ld_ack),
    .err_clr    (err_clr),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid),
    .err_misal  (err_misal),
    .err_tmo    (err_tmo),
    .fsm_state  (fsm_state)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic int size_of(logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit legal_model(logic [2:0] f3, logic [1:0] lane);
    int sz;
    sz = size_of(f3);
    if (sz == 0) return 1'b0;
    return (int'(lane) % sz) == 0;
  endfunction

  function automatic logic [31:0] ext_model(logic [2:0] f3, logic [1:0] lane, logic [31:0] word);
    int sz;
    int off;
    longint v;
    longint span;
    sz   = size_of(f3);
    off  = int'(lane) - (int'(lane) % sz);
    span = longint'(1) << (8 * sz);
    v    = {32'd0, word};
    v    = (v >> (8 * off)) & (span - 1);
    if (!f3[2] && sz < 4 && v >= (span / 2)) v = v - span;
    return v[31:0];
  endfunction

  logic        m_busy, m_valid, m_misal, m_tmo;
  logic [31:0] m_data;
  logic [2:0]  m_f3;
  logic [1:0]  m_lane;
  int          m_waited;

  always @(posedge clk or negedge reset) begin
    bit start;
    if (!reset) begin
      m_busy = 0; m_valid = 0; m_misal = 0; m_tmo = 0;
      m_data = 32'd0; m_f3 = 3'd0; m_lane = 2'd0; m_waited = 0;
    end else begin
      start = 1'b0;
      if (m_misal || m_tmo) begin
        if (err_clr) begin m_misal = 0; m_tmo = 0; end
      end else if (m_busy) begin
        if (mem_valid) begin
          m_data = ext_model(m_f3, m_lane, mem_rdata);
          m_busy = 0;
          m_valid = 1;
        end else if (m_waited + 1 == TMO) begin
          m_busy = 0;
          m_tmo = 1;
        end else begin
          m_waited++;
        end
      end else if (m_valid) begin
        if (ld_ack) begin m_valid = 0; start = ld_req; end
      end else begin
        start = ld_req;
      end
      if (start) begin
        m_f3 = ld_funct3;
        m_lane = addr_lo;
        m_waited = 0;
        if (legal_model(ld_funct3, addr_lo)) m_busy = 1;
        else m_misal = 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("data_valid", 32'(data_valid), 32'(m_valid));
      check("data_out", data_out, m_data);
      check("err_misal", 32'(err_misal), 32'(m_misal));
      check("err_tmo", 32'(err_tmo), 32'(m_tmo));
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Issues a legal load and returns with the DUT holding the result.
  task automatic do_load(input logic [2:0] f3, input logic [1:0] lane,
                         input logic [31:0] word, input int gap);
    ld_req = 1'b1; ld_funct3 = f3; addr_lo = lane;
    step();
    ld_req = 1'b0;
    repeat (gap) step();
    mem_valid = 1'b1; mem_rdata = word;
    step();
    mem_valid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic ack();
    ld_ack = 1'b1;
    step();
    ld_ack = 1'b0;
  endtask

  task automatic load_and_pin(string name, input logic [2:0] f3, input logic [1:0] lane,
                              input logic [31:0] word, input logic [31:0] exp);
    do_load(f3, lane, word, 1);
    settle();
    check({name, "_dut"}, data_out, exp);
    check({name, "_model"}, m_data, exp);
    ack();
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    settle();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    reset = 1'b1;
    checking = 1'b1;
    step();

    // LW, memory answers on the third WAIT cycle
    do_load(F3_LW, 2'd0, 32'h0003_0D40, 2);
    settle();
    check("lw_data", data_out, 32'd200000);
    check("lw_valid", 32'(data_valid), 32'd1);
    mem_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_valid = 1'b0;
    step();
    settle();
    check("lw_held", data_out, 32'd200000);
    check("lw_held_valid", 32'(data_valid), 32'd1);
    ack();
    settle();
    check("lw_after_ack_valid", 32'(data_valid), 32'd0);
    check("lw_after_ack_data", data_out, 32'd200000);

    // lane select and extension
    load_and_pin("lb0", F3_LB, 2'd0, 32'h80F0_7F81, 32'hFFFF_FF81);
    load_and_pin("lbu0", F3_LBU, 2'd0, 32'h80F0_7F81, 32'h0000_0081);
    load_and_pin("lh2", F3_LH, 2'd2, 32'h80F0_7F81, 32'hFFFF_80F0);
    load_and_pin("lhu2", F3_LHU, 2'd2, 32'h80F0_7F81, 32'h0000_80F0);
    load_and_pin("lb1", F3_LB, 2'd1, 32'h80F0_7F81, 32'h0000_007F);
    load_and_pin("lb3", F3_LB, 2'd3, 32'h80F0_7F81, 32'hFFFF_FF80);
    load_and_pin("lbu2", F3_LBU, 2'd2, 32'h80F0_7F81, 32'h0000_00F0);
    load_and_pin("lh0", F3_LH, 2'd0, 32'h1234_8001, 32'hFFFF_8001);

    // misaligned LH, then clear and recover
    ld_req = 1'b1; ld_funct3 = F3_LH; addr_lo = 2'd1;
    step();
    ld_funct3 = F3_LW; addr_lo = 2'd0;
    step();
    ld_req = 1'b0;
    settle();
    check("misal_flag", 32'(err_misal), 32'd1);
    check("misal_busy", 32'(busy), 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    settle();
    check("misal_cleared", 32'(err_misal), 32'd0);
    load_and_pin("recover_lw", F3_LW, 2'd0, 32'h1234_5678, 32'h1234_5678);

    // illegal funct3 and misaligned LW
    ld_req = 1'b1; ld_funct3 = 3'b011; addr_lo = 2'd0;
    step();
    ld_req = 1'b0;
    settle();
    check("illegal_f3", 32'(err_misal), 32'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    ld_req = 1'b1; ld_funct3 = F3_LW; addr_lo = 2'd2;
    step();
    ld_req = 1'b0;
    settle();
    check("lw_misal", 32'(err_misal), 32'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // timeout after exactly TMO empty WAIT cycles
    ld_req = 1'b1; ld_funct3 = F3_LW; addr_lo = 2'd0;
    step();
    ld_req = 1'b0;
    repeat (TMO - 1) step();
    settle();
    check("tmo_still_busy", 32'(busy), 32'd1);
    check("tmo_not_yet", 32'(err_tmo), 32'd0);
    step();
    settle();
    check("tmo_flag", 32'(err_tmo), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    settle();
    check("tmo_cleared", 32'(err_tmo), 32'd0);

    // memory answers on the last allowed cycle
    do_load(F3_LW, 2'd0, 32'hCAFE_F00D, TMO - 1);
    settle();
    check("edge_valid", 32'(data_valid), 32'd1);
    check("edge_no_tmo", 32'(err_tmo), 32'd0);
    check("edge_data", data_out, 32'hCAFE_F00D);

    // back-to-back: ack and new request in the same HOLD cycle
    ld_ack = 1'b1; ld_req = 1'b1; ld_funct3 = F3_LHU; addr_lo = 2'd2;
    step();
    ld_ack = 1'b0; ld_req = 1'b0;
    settle();
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_valid", 32'(data_valid), 32'd0);
    mem_valid = 1'b1; mem_rdata = 32'hA5A5_0000;
    step();
    mem_valid = 1'b0;
    settle();
    check("b2b_data", data_out, 32'h0000_A5A5);
    ack();

    // reset asserted mid-WAIT
    ld_req = 1'b1; ld_funct3 = F3_LW; addr_lo = 2'd0;
    step();
    ld_req = 1'b0;
    step();
    reset = 1'b0;
    settle();
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_data", data_out, 32'd0);
    check("rstw_valid", 32'(data_valid), 32'd0);
    check("rstw_err", {30'd0, err_misal, err_tmo}, 32'd0);
    check("rstw_state", 32'(fsm_state), 32'(ST_IDLE));
    step();
    reset = 1'b1;
    step();
    load_and_pin("post_rst", F3_LBU, 2'd3, 32'h7700_0000, 32'h0000_0077);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
